// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART command interface that issues word reads/writes on
// the core memory bus and returns results over its own UART TX (8N1).
// Optional feature macro: UART_LOADER_AUTOINC_EN. When it is defined, the
// address register advances by 4 after every granted access, and the
// current-address commands 'w'/'r' become available.
module uart_mem_loader #(
    parameter int CLOCK_RATE     = 99_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        mem_valid,
    input  logic        mem_grant,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       r_rx_state;
    logic            r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0]   r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;
    logic            w_rx_valid;
    logic [7:0]      w_rx_byte;

    // Synchronise the async line, find the start edge and shift in 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= CW'(DIV / 2 - 1);
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == '0) begin
                        // A glitch shorter than half a bit is not a start bit.
                        if (!r_rx_sync) begin
                            r_rx_state <= RX_DATA;
                            r_rx_cnt   <= CW'(DIV - 1);
                            r_rx_bit   <= '0;
                        end else begin
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_cnt   <= CW'(DIV - 1);
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                    else                r_rx_cnt   <= r_rx_cnt - 1'b1;
                end
            endcase
        end
    end

    // A byte is delivered in the stop-bit sample cycle; a low stop bit drops it.
    assign w_rx_valid = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && r_rx_sync;
    assign w_rx_byte  = r_rx_shift;

    // ------------------------------------------------------------ TX
    logic            r_tx_line, r_tx_active;
    logic [8:0]      r_tx_shift;
    logic [3:0]      r_tx_left;
    logic [CW-1:0]   r_tx_cnt;
    logic            w_tx_done, w_tx_ready, w_tx_start;
    logic [7:0]      w_tx_data;

    assign w_tx_done  = r_tx_active && (r_tx_cnt == '0) && (r_tx_left == '0);
    // Ready in the last stop-bit cycle too, so reply bytes go out back-to-back.
    assign w_tx_ready = !r_tx_active || w_tx_done;

    // Serialise start, 8 data bits LSB first and stop, DIV cycles each.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_line   <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_left   <= '0;
            r_tx_cnt    <= '0;
        end else if (w_tx_start && w_tx_ready) begin
            r_tx_line   <= 1'b0;
            r_tx_shift  <= {1'b1, w_tx_data};
            r_tx_left   <= 4'd9;
            r_tx_cnt    <= CW'(DIV - 1);
            r_tx_active <= 1'b1;
        end else if (r_tx_active) begin
            if (r_tx_cnt == '0) begin
                if (r_tx_left == '0) begin
                    r_tx_active <= 1'b0;
                end else begin
                    r_tx_line  <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                    r_tx_left  <= r_tx_left - 1'b1;
                    r_tx_cnt   <= CW'(DIV - 1);
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ command FSM
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_RDWAIT, S_RESP} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic          r_write, w_write_nxt;
    logic [31:0]   r_addr, w_addr_nxt;
    logic [31:0]   r_wdata, w_wdata_nxt;
    logic [31:0]   r_resp, w_resp_nxt;
    logic [2:0]    r_resp_len, w_len_nxt;
    logic [2:0]    r_resp_idx, w_idx_nxt;
    logic [TW-1:0] r_to_cnt, w_to_nxt;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_resp_len <= '0;
            r_resp_idx <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_write    <= w_write_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_resp     <= w_resp_nxt;
            r_resp_len <= w_len_nxt;
            r_resp_idx <= w_idx_nxt;
            r_to_cnt   <= w_to_nxt;
        end
    end

    // Next-state logic: decode commands, collect fields, run the access, reply.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_resp_nxt  = r_resp;
        w_len_nxt   = r_resp_len;
        w_idx_nxt   = r_resp_idx;
        w_to_nxt    = r_to_cnt;
        w_tx_start  = 1'b0;
        w_tx_data   = 8'h00;
        case (r_state)
            S_IDLE: begin
                // The command byte is decoded as it arrives, so a one-byte
                // command reaches the bus on the following cycle.
                if (w_rx_valid) begin
                    w_cnt_nxt = '0;
                    w_to_nxt  = '0;
                    case (w_rx_byte)
                        8'h57: begin w_write_nxt = 1'b1; w_state_nxt = S_ADDR; end
                        8'h52: begin w_write_nxt = 1'b0; w_state_nxt = S_ADDR; end
`ifdef UART_LOADER_AUTOINC_EN
                        8'h77: begin w_write_nxt = 1'b1; w_state_nxt = S_DATA; end
                        8'h72: begin w_write_nxt = 1'b0; w_state_nxt = S_REQ;  end
`endif
                        default: begin
                            w_resp_nxt  = 32'h0000_003F;
                            w_len_nxt   = 3'd1;
                            w_idx_nxt   = 3'd0;
                            w_state_nxt = S_RESP;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                // A byte in the timeout cycle takes priority over the abort.
                if (w_rx_valid) begin
                    w_addr_nxt = {w_rx_byte, r_addr[31:8]};
                    w_cnt_nxt  = r_cnt + 1'b1;
                    w_to_nxt   = '0;
                    if (r_cnt == 2'd3) w_state_nxt = r_write ? S_DATA : S_REQ;
                end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_rx_valid) begin
                    w_wdata_nxt = {w_rx_byte, r_wdata[31:8]};
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_to_nxt    = '0;
                    if (r_cnt == 2'd3) w_state_nxt = S_REQ;
                end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            S_REQ: begin
                if (mem_grant) begin
`ifdef UART_LOADER_AUTOINC_EN
                    w_addr_nxt = (r_addr & 32'hFFFF_FFFC) + 32'd4;
`endif
                    if (r_write) begin
                        w_resp_nxt  = 32'h0000_004B;
                        w_len_nxt   = 3'd1;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                // Byte 0 launches straight from the bus to keep grant-to-start short.
                w_resp_nxt  = mem_rdata;
                w_tx_start  = 1'b1;
                w_tx_data   = mem_rdata[7:0];
                w_len_nxt   = 3'd4;
                w_idx_nxt   = 3'd1;
                w_state_nxt = S_RESP;
            end
            default: begin
                if (r_resp_idx == r_resp_len) begin
                    if (w_tx_ready) w_state_nxt = S_IDLE;
                end else if (w_tx_ready) begin
                    w_tx_start = 1'b1;
                    w_tx_data  = r_resp[{r_resp_idx[1:0], 3'b000} +: 8];
                    w_idx_nxt  = r_resp_idx + 1'b1;
                end
            end
        endcase
    end

    assign uart_tx   = r_tx_line;
    assign mem_valid = (r_state == S_REQ);
    assign mem_write = r_write;
    assign mem_wmask = 4'hF;
    assign mem_addr  = r_addr & 32'hFFFF_FFFC;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != S_IDLE) || r_tx_active;

endmodule
